// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter: round-robin arbiter sharing one multi-cycle resource
// port among N requesters. Grants are held until done or watchdog expiry;
// priority then rotates past the last winner. Back-to-back grants have no
// idle bubble.
module shared_port_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             start,
    output logic             timeout
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             timeout_q, timeout_d;

    logic             any_req;
    logic             rel;
    logic             forced;
    logic [IDX_W-1:0] next_base;
    logic [IDX_W-1:0] pick_base;
    logic [IDX_W-1:0] pick_idx;

    // Lowest requester at or above base; falls back to lowest requester overall.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] r,
                                              input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] res_m;
        logic [IDX_W-1:0] res_r;
        logic             found_m;
        res_m   = '0;
        res_r   = '0;
        found_m = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned i;
            i = N - 1 - k;
            if (r[i]) begin
                res_r = IDX_W'(i);
                if (i >= 32'(base)) begin
                    res_m   = IDX_W'(i);
                    found_m = 1'b1;
                end
            end
        end
        return found_m ? res_m : res_r;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

    // Release detection and priority base selection.
    always_comb begin
        any_req   = |req;
        rel       = (state_q == BUSY) &&
                    (done || ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))));
        forced    = rel && !done;
        next_base = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
        pick_base = (state_q == BUSY) ? next_base : ptr_q;
        pick_idx  = pick(req, pick_base);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: enter BUSY on any request, leave only when a release finds no requester.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (rel && !any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, pointer, hold counter and pulse updates.
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                    valid_d = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d     = next_base;
                    timeout_d = forced;
                    if (any_req) begin
                        idx_d   = pick_idx;
                        grant_d = onehot(pick_idx);
                        valid_d = 1'b1;
                        start_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        idx_d   = '0;
                        grant_d = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign start       = start_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Bench for shared_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural round-robin model.
module tb_shared_port_arbiter;

    localparam int N       = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             start;
    logic             timeout;

    shared_port_arbiter #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .start       (start),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current grantee (-1 = none), rotation base, cycles held.
    int m_gnt = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_start = 0;
    bit m_to = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scan requesters starting at base, wrapping around.
    function automatic int rr_pick(input logic [N-1:0] r, input int base);
        for (int off = 0; off < N; off++) begin
            int j;
            j = (base + off) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_gnt = -1; m_ptr = 0; m_cnt = 0; m_start = 0; m_to = 0;
        end else if (m_gnt < 0) begin
            m_to = 0;
            m_gnt = rr_pick(req, m_ptr);
            m_start = (m_gnt >= 0);
            m_cnt = (m_gnt >= 0) ? 1 : 0;
        end else if (done || (TIMEOUT != 0 && m_cnt == TIMEOUT)) begin
            m_to = !done;
            m_ptr = (m_gnt + 1) % N;
            m_gnt = rr_pick(req, m_ptr);
            m_start = (m_gnt >= 0);
            m_cnt = (m_gnt >= 0) ? 1 : 0;
        end else begin
            m_cnt++;
            m_start = 0;
            m_to = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("grant",       32'(grant),       (m_gnt < 0) ? 32'd0 : 32'(1 << m_gnt));
        check("grant_idx",   32'(grant_idx),   (m_gnt < 0) ? 32'd0 : 32'(m_gnt));
        check("grant_valid", 32'(grant_valid), 32'(m_gnt >= 0));
        check("start",       32'(start),       32'(m_start));
        check("timeout",     32'(timeout),     32'(m_to));
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int fair_seq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;

        // Reset state
        do_reset();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_valid", 32'(grant_valid), 32'h0);

        // Basic sequence
        req = 4'b0101; step();
        check("basic_c1_grant", 32'(grant), 32'h1);
        check("basic_c1_start", 32'(start), 32'h1);
        step();
        check("basic_c2_start", 32'(start), 32'h0);
        step();
        done = 1'b1; step();
        check("basic_c4_grant", 32'(grant), 32'h4);
        check("basic_c4_idx", 32'(grant_idx), 32'h2);
        check("basic_c4_start", 32'(start), 32'h1);
        req = '0; step();
        done = 1'b0;
        check("basic_c5_valid", 32'(grant_valid), 32'h0);
        check("basic_c5_grant", 32'(grant), 32'h0);

        // Fairness: all requesting, done every granted cycle
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            done = 1'b1;
            check("fair_idx", 32'(grant_idx), 32'(fair_seq[k]));
            check("fair_start", 32'(start), 32'h1);
        end
        done = 1'b0;

        // Wrap and rotation
        do_reset();
        req = 4'b0100; step();
        check("wrap_first_idx", 32'(grant_idx), 32'h2);
        req = 4'b0011; done = 1'b1; step();
        check("wrap_idx0", 32'(grant_idx), 32'h0);
        step();
        check("wrap_idx1", 32'(grant_idx), 32'h1);
        done = 1'b0; req = '0; step();

        // Watchdog forced release
        do_reset();
        req = 4'b0010; step();
        req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("wd_hold_idx", 32'(grant_idx), 32'h1);
            check("wd_hold_valid", 32'(grant_valid), 32'h1);
        end
        step();
        check("wd_release_valid", 32'(grant_valid), 32'h0);
        check("wd_timeout", 32'(timeout), 32'h1);
        step();
        check("wd_timeout_pulse", 32'(timeout), 32'h0);
        req = 4'b0110; step();
        check("wd_ptr_rotated", 32'(grant_idx), 32'h2);
        req = '0; done = 1'b1; step(); done = 1'b0;

        // done coinciding with expiry
        do_reset();
        req = 4'b0010; step();
        req = '0; step(); step(); step();
        done = 1'b1; step(); done = 1'b0;
        check("wd_done_wins_timeout", 32'(timeout), 32'h0);
        check("wd_done_wins_valid", 32'(grant_valid), 32'h0);

        // Dropped request holds grant; done while idle ignored
        do_reset();
        req = 4'b1000; step();
        req = '0; step();
        check("drop_hold", 32'(grant), 32'h8);
        done = 1'b1; step(); done = 1'b0;
        check("drop_release", 32'(grant_valid), 32'h0);
        done = 1'b1; step(); done = 1'b0;
        check("idle_done_valid", 32'(grant_valid), 32'h0);
        check("idle_done_timeout", 32'(timeout), 32'h0);

        // Reset in the second grant cycle
        do_reset();
        req = 4'b0100; step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        check("midreset_valid", 32'(grant_valid), 32'h0);
        check("midreset_timeout", 32'(timeout), 32'h0);
        req = 4'b1001; step();
        check("midreset_regrant", 32'(grant_idx), 32'h0);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            done = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_port_arbiter.md
# shared_port_arbiter

Round-robin arbiter that shares one multi-cycle resource port (e.g. a memory or long-latency functional-unit port in mips_core) among N requesters. A request is granted through a rotating-priority select. The grant is held until the resource signals completion or a watchdog expires. Priority then rotates past the last winner so no requester starves. The block sits between the requesting units and the resource; it issues a one-cycle start pulse to launch each transaction.

## Interface
- N, default 4: number of requesters (≥1, need not be a power of two).
- IDX_W, default 2: width of grant index, $clog2(N) (minimum 1).
- TIMEOUT, default 255: maximum granted cycles per transaction; 0 disables the watchdog.

- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: reset; synchronous, active-high.
- req, in, N: request vector, bit i = requester i; level, held by requester until served.
- done, in, 1: resource completion; valid only while grant_valid=1.
- grant, out, N: one-hot grant vector, registered.
- grant_idx, out, IDX_W: binary index of granted requester, registered.
- grant_valid, out, 1: a grant is active, registered.
- start, out, 1: one-cycle pulse in the first cycle of each grant, registered.
- timeout, out, 1: one-cycle pulse in the cycle after a watchdog-forced release, registered.

## Operation
- Internal state: FSM {IDLE, BUSY}; rotating pointer ptr (0..N-1); hold counter cnt (sized for TIMEOUT).
- Pick function (combinational): masked = req with bits below base cleared. If masked≠0, pick the lowest set index of masked; else pick the lowest set index of req.
  - base = ptr in IDLE.
  - base = (grant_idx+1) mod N on a release cycle.
- IDLE: if req≠0, pick with base=ptr, load grant/grant_idx, grant_valid=1, start=1, cnt=1, go to BUSY. Else all grant outputs stay 0.
- BUSY, no release: grant, grant_idx and grant_valid hold; start=0; cnt increments. req changes are ignored (dropping req does not cancel a grant).
- Release cycle:
  - A release occurs when done=1, or when TIMEOUT≠0, cnt==TIMEOUT and done=0.
  - On release, ptr ← (grant_idx+1) mod N.
  - Then pick with the new base over the current req, including the releasing requester's bit at lowest rotated priority. If any request remains: new grant next cycle with start=1, cnt=1, stay in BUSY (zero-bubble back-to-back). Else clear grant outputs and go to IDLE.
  - timeout=1 in the next cycle only if the release was forced. If done and expiry coincide, done wins and timeout=0.
- done while IDLE is ignored.
- Pointer wrap: after granting index N-1, ptr=0.
- N=1: the single requester is re-granted every time it requests; ptr stays 0.

## Timing
- Reset values: grant=0, grant_idx=0, grant_valid=0, start=0, timeout=0, ptr=0, cnt=0, state=IDLE.
- Reset mid-transaction: all of the above take effect at the next edge; the active grant is dropped with no timeout pulse.
- Latency, IDLE to grant: req sampled at edge k gives grant visible in cycle k+1.
- Release to next grant: done sampled at edge k gives the old grant gone and the new grant (if any) visible in cycle k+1; no idle cycle.
- Grant length: from 1 cycle (done in the start cycle) to TIMEOUT cycles.
- grant is always one-hot or zero, and is consistent with grant_idx and grant_valid in every cycle.

## Test plan
- Basic: reset, then req=4'b0101 at cycle 0. Cycle 1: grant=0001, idx=0, start=1. done=1 in cycle 3. Cycle 4: grant=0100, idx=2, start=1. done in cycle 4 with req=0. Cycle 5: IDLE, all outputs 0.
- Fairness: req=1111 held, done asserted in every granted cycle. Grant order is 0,1,2,3,0,1; start=1 every cycle; no bubbles.
- Wrap/rotation: after serving idx 2 (ptr=3), req=0011 gives idx 0. Then req=0011 again after release gives idx 1, not idx 0.
- Watchdog: TIMEOUT=4, req=0010, done never asserted. Grant idx 1 for exactly 4 cycles, then grant_valid=0 with timeout=1 for one cycle, ptr=2. Repeat with done in the 4th granted cycle: timeout stays 0.
- Robustness: drop req mid-grant, grant holds until done. done pulsed while IDLE: no state change. Reset in the 2nd grant cycle: next cycle all outputs 0, and req=1001 then grants idx 0.
